// File: rtl/oob_ila_capture_if.sv
// Probe, trigger-setup and read-back bundle for the OOB/link logic-analyzer capture core.
// master = debug host / bench side, slave = capture core.
interface oob_ila_capture_if #(
  parameter int C_AW = 10
);
  logic            arm;
  logic [127:0]    trig0;
  logic [127:0]    trig_mask;
  logic [127:0]    trig_value;
  logic            trig_out;
  logic            armed;
  logic            done;
  logic [C_AW-1:0] trig_addr;
  logic [C_AW-1:0] rd_addr;
  logic [127:0]    rd_data;

  modport master (
    output arm, trig0, trig_mask, trig_value, rd_addr,
    input  trig_out, armed, done, trig_addr, rd_data
  );

  modport slave (
    input  arm, trig0, trig_mask, trig_value, rd_addr,
    output trig_out, armed, done, trig_addr, rd_data
  );
endinterface

// File: rtl/oob_ila_capture.sv
// 128-bit ILA capture: arm (3-flop sync + edge) -> pre-fill -> masked trigger -> post-fill -> DONE.
// Samples are one register behind trig0; read-back is one cycle; there is no backpressure.
module oob_ila_capture #(
  parameter int C_DEPTH   = 1024,
  parameter int C_AW      = 10,
  parameter int C_PRETRIG = 512
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  oob_ila_capture_if.slave dbg
);

  localparam logic [C_AW-1:0] PRE_A     = C_AW'(C_PRETRIG);
  localparam int              C_POST    = C_DEPTH - 1 - C_PRETRIG;
  localparam bit              POST_NONE = (C_POST == 0);
  localparam logic [C_AW-1:0] POST_LAST = C_AW'((C_POST > 0) ? C_POST - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_TRIG,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic            arm_s1, arm_s2, arm_s3;
  logic            arm_pulse;
  logic [127:0]    d1_q;
  logic            match;
  logic            eligible;
  logic            wr_en;
  logic            clr;
  logic            trig_hit;
  logic [C_AW-1:0] wr_ptr_q;
  logic [C_AW-1:0] pre_cnt_q;
  logic [C_AW-1:0] post_cnt_q;
  logic [C_AW-1:0] trig_addr_q;
  logic            trig_out_q;
  logic [C_AW-1:0] rd_idx;
  logic [127:0]    rd_data_q;
  logic [127:0]    mem [C_DEPTH];

  assign arm_pulse = arm_s2 & ~arm_s3;
  assign match     = (((d1_q ^ dbg.trig_value) & dbg.trig_mask) == '0);
  // Only samples that already have a full pre-trigger history may fire.
  assign eligible  = (pre_cnt_q == PRE_A);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arm always wins: any arm edge restarts the capture, even on a trigger cycle.
  always_comb begin
    state_d  = state_q;
    wr_en    = 1'b0;
    clr      = 1'b0;
    trig_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arm_pulse) begin
          clr     = 1'b1;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (arm_pulse) begin
          clr = 1'b1;
        end else begin
          wr_en = 1'b1;
          if (eligible && match) begin
            trig_hit = 1'b1;
            state_d  = POST_NONE ? S_DONE : S_TRIG;
          end
        end
      end
      S_TRIG: begin
        if (arm_pulse) begin
          clr     = 1'b1;
          state_d = S_ARMED;
        end else begin
          wr_en = 1'b1;
          if (post_cnt_q == POST_LAST) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (arm_pulse) begin
          clr     = 1'b1;
          state_d = S_ARMED;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      arm_s1      <= 1'b0;
      arm_s2      <= 1'b0;
      arm_s3      <= 1'b0;
      d1_q        <= '0;
      wr_ptr_q    <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      trig_addr_q <= '0;
      trig_out_q  <= 1'b0;
    end else begin
      arm_s1     <= dbg.arm;
      arm_s2     <= arm_s1;
      arm_s3     <= arm_s2;
      d1_q       <= dbg.trig0;
      trig_out_q <= trig_hit;
      if (trig_hit) begin
        trig_addr_q <= wr_ptr_q;
      end
      if (clr) begin
        wr_ptr_q   <= '0;
        pre_cnt_q  <= '0;
        post_cnt_q <= '0;
      end else if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (state_q == S_ARMED && !eligible) begin
          pre_cnt_q <= pre_cnt_q + 1'b1;
        end
        if (state_q == S_TRIG) begin
          post_cnt_q <= post_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= d1_q;
    end
  end

  // Window index 0 is the oldest sample, C_PRETRIG slots before the trigger.
  assign rd_idx = trig_addr_q - PRE_A + dbg.rd_addr;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[rd_idx];
    end
  end

  assign dbg.trig_out  = trig_out_q;
  assign dbg.armed     = (state_q == S_ARMED) || (state_q == S_TRIG);
  assign dbg.done      = (state_q == S_DONE);
  assign dbg.trig_addr = trig_addr_q;
  assign dbg.rd_data   = rd_data_q;

endmodule

// File: tb/tb_oob_ila_capture.sv
// Directed bench for oob_ila_capture (16-deep, 4 pre-trigger samples) with a trigger/read-back scoreboard.
module tb_oob_ila_capture;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int PRE   = 4;
  localparam logic [127:0] ONES = {128{1'b1}};

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  oob_ila_capture_if #(.C_AW(AW)) dbg();

  oob_ila_capture #(
    .C_DEPTH  (DEPTH),
    .C_AW     (AW),
    .C_PRETRIG(PRE)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .dbg      (dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] exp_trig_q[$];
  logic [127:0]  exp_rd_q[$];
  logic [AW-1:0] mon_trig_e;
  logic [127:0]  mon_rd_e;
  logic          rd_req   = 1'b0;
  logic          rd_req_d = 1'b0;
  logic          cnt_en   = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge sys_clk) rd_req_d <= rd_req;

  // Monitor: every trigger pulse and every read return is matched against the queues.
  always @(negedge sys_clk) begin
    if (dbg.trig_out === 1'b1) begin
      if (exp_trig_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL trig_unexpected: got trig_out=1 trig_addr=%0h, expected no trigger", dbg.trig_addr);
      end else begin
        mon_trig_e = exp_trig_q.pop_front();
        check("trig_addr", {124'd0, dbg.trig_addr}, {124'd0, mon_trig_e});
      end
    end
    if (rd_req_d) begin
      if (exp_rd_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_unexpected: got rd_data=%0h with no expected entry", dbg.rd_data);
      end else begin
        mon_rd_e = exp_rd_q.pop_front();
        check("rd_data", dbg.rd_data, mon_rd_e);
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
    if (cnt_en) dbg.trig0 = dbg.trig0 + 128'd1;
  endtask

  // Called just after a tick: that edge counts as edge 0 of the arm request.
  task automatic arm_edge(input logic [127:0] mask, input logic [127:0] value);
    dbg.trig_mask  = mask;
    dbg.trig_value = value;
    dbg.arm        = 1'b1;
    dbg.trig0      = '0;
    cnt_en         = 1'b1;
  endtask

  task automatic wait_trig(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (dbg.trig_out === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, {127'd0, ok}, 128'd1);
  endtask

  task automatic count_to_done(input string name, input int exp_n);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (dbg.done !== 1'b1 && n < 200);
    check(name, n, exp_n);
  endtask

  task automatic readback(input logic [127:0] first);
    for (int i = 0; i < DEPTH; i++) begin
      exp_rd_q.push_back(first + 128'(i));
      dbg.rd_addr = i[AW-1:0];
      rd_req      = 1'b1;
      tick();
    end
    rd_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic disarm();
    dbg.arm = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    bit ok;
    dbg.arm        = 1'b0;
    dbg.trig0      = '0;
    dbg.trig_mask  = '0;
    dbg.trig_value = '0;
    dbg.rd_addr    = '0;
    #3;
    check("rst_armed", {127'd0, dbg.armed}, 128'd0);
    check("rst_done", {127'd0, dbg.done}, 128'd0);
    check("rst_trig_out", {127'd0, dbg.trig_out}, 128'd0);
    check("rst_trig_addr", {124'd0, dbg.trig_addr}, 128'd0);
    check("rst_rd_data", dbg.rd_data, 128'd0);
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();
    tick();

    // Arm held high through the whole capture and beyond: exactly one arm event.
    arm_edge(ONES, 128'd20);
    exp_trig_q.push_back(4'd2);
    tick();
    tick();
    check("arm_sync_edge2", {127'd0, dbg.armed}, 128'd0);
    tick();
    check("arm_sync_edge3", {127'd0, dbg.armed}, 128'd1);
    wait_trig("trig_value20");
    count_to_done("post_len_v20", 11);
    bad = 1'b0;
    repeat (25) begin
      tick();
      if (dbg.done !== 1'b1 || dbg.armed !== 1'b0) bad = 1'b1;
    end
    check("arm_held_single_pulse", {127'd0, bad}, 128'd0);
    readback(128'd16);

    // Match on the 2nd sample is ineligible; next match (sample 11) fires.
    disarm();
    arm_edge(128'h7, 128'h3);
    exp_trig_q.push_back(4'd9);
    wait_trig("trig_prefill");
    count_to_done("post_len_prefill", 11);
    readback(128'd7);

    // Zero mask: first eligible (5th) sample triggers.
    disarm();
    arm_edge('0, '0);
    exp_trig_q.push_back(4'd4);
    wait_trig("trig_mask0");
    count_to_done("post_len_mask0", 11);
    check("done_mask0", {127'd0, dbg.done}, 128'd1);
    readback(128'd2);

    // Re-arm while TRIGGERED: capture restarts with a new trigger value.
    disarm();
    arm_edge(ONES, 128'd20);
    tick();
    dbg.arm = 1'b0;
    exp_trig_q.push_back(4'd2);
    wait_trig("trig_before_rearm");
    dbg.trig_value = 128'd30;
    dbg.arm        = 1'b1;
    exp_trig_q.push_back(4'd6);
    bad = 1'b0;
    ok  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (dbg.armed !== 1'b1 || dbg.done !== 1'b0) bad = 1'b1;
      if (dbg.trig_out === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("trig_after_rearm", {127'd0, ok}, 128'd1);
    check("rearm_status", {127'd0, bad}, 128'd0);
    count_to_done("post_len_rearm", 11);
    readback(128'd26);

    // Async reset mid-ARMED clears status without a clock edge.
    disarm();
    arm_edge(ONES, 128'd1000);
    repeat (6) tick();
    check("armed_before_rst", {127'd0, dbg.armed}, 128'd1);
    sys_rst_n = 1'b0;
    dbg.arm   = 1'b0;
    #1;
    check("async_rst_armed", {127'd0, dbg.armed}, 128'd0);
    check("async_rst_done", {127'd0, dbg.done}, 128'd0);
    check("async_rst_trig_out", {127'd0, dbg.trig_out}, 128'd0);
    tick();
    tick();
    sys_rst_n      = 1'b1;
    dbg.trig_value = 128'd20;
    bad = 1'b0;
    repeat (40) begin
      tick();
      if (dbg.armed !== 1'b0) bad = 1'b1;
    end
    check("idle_after_rst", {127'd0, bad}, 128'd0);
    arm_edge(ONES, 128'd20);
    exp_trig_q.push_back(4'd2);
    wait_trig("trig_after_rst");
    count_to_done("post_len_after_rst", 11);
    readback(128'd16);

    repeat (3) tick();
    check("trig_queue_drained", exp_trig_q.size(), 128'd0);
    check("rd_queue_drained", exp_rd_q.size(), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
